matrix_result_reader: RTL and testbench

- Reader end of the matrix multiplier's result interface.
- Watches the multiplier's done flag and snapshots the flat N×N result bus into a shadow register.
- Streams the elements out one per handshake, row-major, on a valid/ready byte stream with first/last, row and column tags.
- Sits between the 10x10 multiplier and the downstream UART/host transmit path.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/matrix_result_reader_if.sv | 22 ++
 rtl/matrix_result_reader.sv | 128 ++++++++++++
 tb/tb_matrix_result_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier datapath: dimensions,
// state encoding and the flat-bus element offset helper.
package matrix_pkg;

    localparam int N      = 10;
    localparam int W      = 8;
    localparam int IDX_W  = 7;
    localparam int RC_W   = 4;
    localparam int FLAT_W = N * N * W;
    localparam int LSB_W  = $clog2(FLAT_W);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Bit offset of element (p,q) inside the flat row-major result bus.
    function automatic int unsigned elem_lsb(input int unsigned p, input int unsigned q);
        return W * (N * p + q);
    endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// Element stream from the result reader to the transmit path.
interface matrix_result_reader_if import matrix_pkg::*;;

    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_first;
    logic            out_last;
    logic [RC_W-1:0] out_row;
    logic [RC_W-1:0] out_col;

    modport master (
        output out_data, out_valid, out_first, out_last, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_first, out_last, out_row, out_col,
        output out_ready
    );

endinterface

// File: rtl/matrix_result_reader.sv
// Snapshots the multiplier result on a done rise and streams it out
// row-major, one element per valid/ready handshake.
//
// state  | meaning
// IDLE   | no frame held, waiting for done to rise
// STREAM | shadow holds a frame, presenting element (row,col)
module matrix_result_reader
    import matrix_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLAT_W-1:0]     result_array,
    input  logic                  done,
    matrix_result_reader_if.master m_if,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clear_overrun
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic [FLAT_W-1:0] shadow_q, shadow_d;
    logic              overrun_q, overrun_d;
    logic              done_q;

    logic              done_rise;
    logic              streaming;
    logic              xfer;
    logic              last_idx;
    logic              last_xfer;
    logic              capture;
    logic              ovr_evt;
    logic [LSB_W-1:0]  elem_sel;

    // Handshake qualifiers; a rise coinciding with the final beat chains frames.
    always_comb begin
        done_rise = done & ~done_q;
        streaming = (state_q == STREAM);
        xfer      = streaming & m_if.out_ready;
        last_idx  = (idx_q == IDX_W'(N * N - 1));
        last_xfer = xfer & last_idx;
        capture   = done_rise & (~streaming | last_xfer);
        ovr_evt   = done_rise & streaming & ~last_xfer;
        elem_sel  = LSB_W'(elem_lsb(32'(row_q), 32'(col_q)));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_rise) state_d = STREAM;
            STREAM:  if (last_xfer && !done_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, shadow and sticky-flag next values; set of overrun beats clear.
    always_comb begin
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
        if (clear_overrun) overrun_d = 1'b0;
        if (ovr_evt)       overrun_d = 1'b1;
        if (capture) begin
            shadow_d = result_array;
            idx_d    = '0;
            row_d    = '0;
            col_d    = '0;
        end else if (last_xfer) begin
            idx_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_q == RC_W'(N - 1)) begin
                col_d = '0;
                row_d = row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
            done_q    <= done;
        end
    end

    // Outputs are decoded from state so valid drops as soon as reset asserts.
    always_comb begin
        m_if.out_valid = streaming;
        m_if.out_data  = streaming ? shadow_q[elem_sel +: W] : '0;
        m_if.out_first = streaming & (idx_q == '0);
        m_if.out_last  = streaming & last_idx;
        m_if.out_row   = streaming ? row_q : '0;
        m_if.out_col   = streaming ? col_q : '0;
        busy           = streaming;
        overrun        = overrun_q;
    end

endmodule

// File: tb/tb_matrix_result_reader.sv
module tb_matrix_result_reader;
    import matrix_pkg::*;

    logic              clk;
    logic              reset;
    logic [FLAT_W-1:0] result_array;
    logic              done;
    logic              busy;
    logic              overrun;
    logic              clear_overrun;
    int                n_chk;
    int                n_pass;
    int                exp_mode;

    matrix_result_reader_if m_if();

    matrix_result_reader dut (
        .clk           (clk),
        .reset         (reset),
        .result_array  (result_array),
        .done          (done),
        .m_if          (m_if),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // mode 0: element k = k; mode 1: element k = 0x63-k; other: all 0xFF
    function automatic int exp_data(input int mode, input int k);
        case (mode)
            0:       return k;
            1:       return 8'h63 - k;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [FLAT_W-1:0] make_frame(input int mode);
        logic [FLAT_W-1:0] v;
        logic [LSB_W-1:0]  off;
        v = '0;
        for (int k = 0; k < N * N; k++) begin
            off = LSB_W'(k * W);
            v[off +: W] = W'(exp_data(mode, k));
        end
        return v;
    endfunction

    task automatic check_beat(input int k);
        check($sformatf("valid[%0d]", k), 32'(m_if.out_valid), 32'd1);
        check($sformatf("data[%0d]", k),  32'(m_if.out_data),  32'(exp_data(exp_mode, k)));
        check($sformatf("row[%0d]", k),   32'(m_if.out_row),   32'(k / N));
        check($sformatf("col[%0d]", k),   32'(m_if.out_col),   32'(k % N));
        check($sformatf("first[%0d]", k), 32'(m_if.out_first), 32'(k == 0));
        check($sformatf("last[%0d]", k),  32'(m_if.out_last),  32'(k == N * N - 1));
        check($sformatf("busy[%0d]", k),  32'(busy),           32'd1);
    endtask

    // Entered at a negedge with beat from_k presented; returns at the negedge
    // after beat to_k has transferred. bp selects the 1,0,0,1 ready pattern.
    task automatic step(input int from_k, input int to_k, input bit bp);
        int k;
        int cyc;
        k   = from_k;
        cyc = 0;
        while (k <= to_k && cyc < 400) begin
            check_beat(k);
            m_if.out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (m_if.out_ready) k++;
            cyc++;
        end
        check($sformatf("beats_to_%0d", to_k), 32'(k), 32'(to_k + 1));
    endtask

    task automatic start_frame(input int mode);
        result_array = make_frame(mode);
        done         = 1'b1;
        check("pre_valid", 32'(m_if.out_valid), 32'd0);
        @(negedge clk);
        exp_mode = mode;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(m_if.out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        exp_mode       = 0;
        reset          = 1'b0;
        done           = 1'b0;
        clear_overrun  = 1'b0;
        m_if.out_ready = 1'b0;
        result_array   = '0;
        repeat (2) @(negedge clk);

        check("rst_valid",   32'(m_if.out_valid), 32'd0);
        check("rst_busy",    32'(busy),           32'd0);
        check("rst_overrun", 32'(overrun),        32'd0);
        check("rst_data",    32'(m_if.out_data),  32'd0);
        check("rst_first",   32'(m_if.out_first), 32'd0);
        check("rst_last",    32'(m_if.out_last),  32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // basic frame at full rate
        start_frame(0);
        step(0, 99, 1'b0);
        check_idle("basic_end");
        done = 1'b0;
        @(negedge clk);

        // backpressure
        start_frame(0);
        step(0, 99, 1'b1);
        check_idle("bp_end");
        done = 1'b0;
        @(negedge clk);

        // overrun: second rise at beat 40 with clear asserted on the same edge
        start_frame(0);
        step(0, 9, 1'b0);
        done = 1'b0;
        step(10, 38, 1'b0);
        result_array = make_frame(2);
        step(39, 39, 1'b0);
        done          = 1'b1;
        clear_overrun = 1'b1;
        step(40, 40, 1'b0);
        clear_overrun = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        step(41, 99, 1'b0);
        check_idle("ovr_end");
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // back-to-back frames: rise on the edge of the last transfer
        start_frame(0);
        step(0, 9, 1'b0);
        done = 1'b0;
        step(10, 98, 1'b0);
        result_array = make_frame(1);
        done         = 1'b1;
        step(99, 99, 1'b0);
        exp_mode = 1;
        check("b2b_first", 32'(m_if.out_first), 32'd1);
        check("b2b_data",  32'(m_if.out_data),  32'h63);
        check("b2b_ovr",   32'(overrun),        32'd0);
        step(0, 99, 1'b0);
        check_idle("b2b_end");
        check("b2b_ovr_end", 32'(overrun), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // reset mid-stream with done held high
        start_frame(0);
        step(0, 36, 1'b0);
        check_beat(37);
        #2 reset = 1'b0;
        result_array = make_frame(1);
        #1;
        check("mid_rst_valid", 32'(m_if.out_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),           32'd0);
        check("mid_rst_data",  32'(m_if.out_data),  32'd0);
        check("mid_rst_row",   32'(m_if.out_row),   32'd0);
        check("mid_rst_col",   32'(m_if.out_col),   32'd0);
        check("mid_rst_last",  32'(m_if.out_last),  32'd0);
        @(negedge clk);
        check("rst_hold_valid", 32'(m_if.out_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        exp_mode = 1;
        step(0, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
